gpu_divider_pipe: RTL and testbench

GPU_DIVIDER_PIPE -- requirements
Module: gpu_divider_pipe

---
 rtl/gpu_div_pkg.sv | 35 +++
 rtl/gpu_div_stage.sv | 66 ++++++
 rtl/gpu_divider_pipe.sv | 176 +++++++++++++++++
 tb/tb_gpu_divider_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_div_pkg.sv
// -----------------------------------------------------------------------------
// gpu_div_pkg
// Shared definitions for the pipelined signed divider:
//   - default width constants (numerator, denominator, output, tag, bits/stage)
//   - div_lat(): pipeline latency in unstalled cycles
//   - div_payload_t: per-stage payload carried between iteration stages
// The payload struct is sized by the package constants; module parameters may
// be equal to or narrower than these and use the low bits of each field.
// -----------------------------------------------------------------------------
package gpu_div_pkg;

    localparam int DIV_NUM_W = 32;
    localparam int DIV_DEN_W = 22;
    localparam int DIV_OUT_W = 20;
    localparam int DIV_BPS   = 8;
    localparam int DIV_TAG_W = 8;

    // Partial remainder, dividend/quotient shift register, |denominator|,
    // numerator sign, quotient sign, zero-denominator flag and sideband tag.
    typedef struct packed {
        logic [DIV_DEN_W-1:0] rem;
        logic [DIV_NUM_W-1:0] quo;
        logic [DIV_DEN_W-1:0] den;
        logic                 num_neg;
        logic                 quo_neg;
        logic                 zero;
        logic [DIV_TAG_W-1:0] tag;
    } div_payload_t;

    // Input register + one register per iteration stage + output register.
    function automatic int div_lat(input int num_w, input int bps);
        return (num_w / bps) + 32'sd2;
    endfunction

endpackage

// File: rtl/gpu_div_stage.sv
// -----------------------------------------------------------------------------
// gpu_div_stage
// One restoring-division iteration stage resolving BPS quotient bits per cycle.
// Ports:
//   clock, reset (async, active-high), stall (hold all state)
//   in_valid / in_pl   : payload from previous stage
//   out_valid / out_pl : registered payload to next stage
// The quo field acts as a combined shift register: dividend bits leave at the
// top while quotient bits enter at the bottom.
// -----------------------------------------------------------------------------
module gpu_div_stage
    import gpu_div_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W,
    parameter int BPS   = DIV_BPS
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         stall,
    input  logic         in_valid,
    input  div_payload_t in_pl,
    output logic         out_valid,
    output div_payload_t out_pl
);

    logic [DEN_W-1:0] rem_s;
    logic [NUM_W-1:0] quo_s;
    logic [DEN_W:0]   trial_s;
    div_payload_t     next_pl_s;

    // Unrolled BPS restoring steps: shift in a dividend bit, subtract if it fits.
    // With a zero divisor every step "fits", so rem simply collects the low
    // dividend bits; the output stage relies on that for the div-by-zero remainder.
    always_comb begin
        rem_s   = in_pl.rem[DEN_W-1:0];
        quo_s   = in_pl.quo[NUM_W-1:0];
        trial_s = {(DEN_W+1){1'b0}};
        for (int i = 0; i < BPS; i++) begin
            trial_s = {rem_s, quo_s[NUM_W-1]};
            quo_s   = {quo_s[NUM_W-2:0], 1'b0};
            if (trial_s >= {1'b0, in_pl.den[DEN_W-1:0]}) begin
                trial_s  = trial_s - {1'b0, in_pl.den[DEN_W-1:0]};
                quo_s[0] = 1'b1;
            end else begin
                quo_s[0] = 1'b0;
            end
            rem_s = trial_s[DEN_W-1:0];
        end
        next_pl_s                 = in_pl;
        next_pl_s.rem[DEN_W-1:0]  = rem_s;
        next_pl_s.quo[NUM_W-1:0]  = quo_s;
    end

    // Stage register; frozen while stalled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_pl    <= '0;
        end else if (!stall) begin
            out_valid <= in_valid;
            out_pl    <= next_pl_s;
        end
    end

endmodule

// File: rtl/gpu_divider_pipe.sv
// -----------------------------------------------------------------------------
// gpu_divider_pipe
// Fully pipelined signed divider, truncating toward zero, saturated quotient.
// Latency div_lat(NUM_W, BPS) unstalled cycles, one operation per cycle.
// Ports:
//   clock, reset (async, active-high), i_stall (freeze whole pipe)
//   i_valid, i_numer[NUM_W], i_denom[DEN_W], i_tag[TAG_W]
//   o_valid, o_quot[OUT_W], o_remain[DEN_W], o_tag[TAG_W], o_divZero, o_ovf
// Build option: GPU_DIV_REMAINDER_EN enables the signed remainder output;
// without it o_remain is constant zero.
// -----------------------------------------------------------------------------
module gpu_divider_pipe
    import gpu_div_pkg::*;
#(
    parameter int NUM_W = DIV_NUM_W,
    parameter int DEN_W = DIV_DEN_W,
    parameter int OUT_W = DIV_OUT_W,
    parameter int BPS   = DIV_BPS,
    parameter int TAG_W = DIV_TAG_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic [NUM_W-1:0] i_numer,
    input  logic [DEN_W-1:0] i_denom,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_quot,
    output logic [DEN_W-1:0] o_remain,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_divZero,
    output logic             o_ovf
);

    localparam int NSTG = NUM_W / BPS;
    localparam logic [NUM_W-1:0] ONE_N   = {{(NUM_W-1){1'b0}}, 1'b1};
    // Largest positive magnitude and largest negative magnitude representable.
    localparam logic [NUM_W-1:0] POS_LIM = (ONE_N << (OUT_W-1)) - ONE_N;
    localparam logic [NUM_W-1:0] NEG_LIM = (ONE_N << (OUT_W-1));
    localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [NUM_W-1:0] num_mag_s;
    logic [DEN_W-1:0] den_mag_s;
    div_payload_t     s0_pl_s;
    logic             s0_valid_r;
    div_payload_t     s0_pl_r;

    logic             stg_valid_s [0:NSTG];
    div_payload_t     stg_pl_s    [0:NSTG];
    div_payload_t     fin_pl_s;

    logic [NUM_W-1:0] q_mag_s;
    logic [OUT_W-1:0] quot_s;
    logic             ovf_s;
    logic             unused_s;

    // Input stage: magnitudes (NUM_W unsigned holds 2^(NUM_W-1)), signs, zero detect.
    always_comb begin
        num_mag_s = i_numer[NUM_W-1] ? ({NUM_W{1'b0}} - i_numer) : i_numer;
        den_mag_s = i_denom[DEN_W-1] ? ({DEN_W{1'b0}} - i_denom) : i_denom;
        s0_pl_s                  = '0;
        s0_pl_s.quo[NUM_W-1:0]   = num_mag_s;
        s0_pl_s.den[DEN_W-1:0]   = den_mag_s;
        s0_pl_s.num_neg          = i_numer[NUM_W-1];
        s0_pl_s.quo_neg          = i_numer[NUM_W-1] ^ i_denom[DEN_W-1];
        s0_pl_s.zero             = (i_denom == {DEN_W{1'b0}});
        s0_pl_s.tag[TAG_W-1:0]   = i_tag;
    end

    // Input stage register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s0_valid_r <= 1'b0;
            s0_pl_r    <= '0;
        end else if (!i_stall) begin
            s0_valid_r <= i_valid;
            s0_pl_r    <= s0_pl_s;
        end
    end

    assign stg_valid_s[0] = s0_valid_r;
    assign stg_pl_s[0]    = s0_pl_r;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        gpu_div_stage #(
            .NUM_W (NUM_W),
            .DEN_W (DEN_W),
            .BPS   (BPS)
        ) u_stage (
            .clock     (clock),
            .reset     (reset),
            .stall     (i_stall),
            .in_valid  (stg_valid_s[k]),
            .in_pl     (stg_pl_s[k]),
            .out_valid (stg_valid_s[k+1]),
            .out_pl    (stg_pl_s[k+1])
        );
    end

    assign fin_pl_s = stg_pl_s[NSTG];

    // Sign fix and saturation of the full-width quotient magnitude.
    always_comb begin
        q_mag_s = fin_pl_s.quo[NUM_W-1:0];
        quot_s  = q_mag_s[OUT_W-1:0];
        ovf_s   = 1'b0;
        if (fin_pl_s.zero) begin
            ovf_s  = 1'b1;
            quot_s = fin_pl_s.num_neg ? OUT_MIN : OUT_MAX;
        end else if (fin_pl_s.quo_neg) begin
            if (q_mag_s > NEG_LIM) begin
                ovf_s  = 1'b1;
                quot_s = OUT_MIN;
            end else begin
                quot_s = {OUT_W{1'b0}} - q_mag_s[OUT_W-1:0];
            end
        end else begin
            if (q_mag_s > POS_LIM) begin
                ovf_s  = 1'b1;
                quot_s = OUT_MAX;
            end else begin
                quot_s = q_mag_s[OUT_W-1:0];
            end
        end
    end

    // Output register; result fields only update when a valid result arrives.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_valid   <= 1'b0;
            o_quot    <= {OUT_W{1'b0}};
            o_tag     <= {TAG_W{1'b0}};
            o_divZero <= 1'b0;
            o_ovf     <= 1'b0;
        end else if (!i_stall) begin
            o_valid <= stg_valid_s[NSTG];
            if (stg_valid_s[NSTG]) begin
                o_quot    <= quot_s;
                o_tag     <= fin_pl_s.tag[TAG_W-1:0];
                o_divZero <= fin_pl_s.zero;
                o_ovf     <= ovf_s;
            end
        end
    end

`ifdef GPU_DIV_REMAINDER_EN
    logic [DEN_W-1:0] rem_fix_s;

    // Remainder takes the numerator sign; for a zero divisor the magnitude is
    // |numer| low bits, so negating yields the numerator truncated to DEN_W.
    always_comb begin
        if (fin_pl_s.num_neg) begin
            rem_fix_s = {DEN_W{1'b0}} - fin_pl_s.rem[DEN_W-1:0];
        end else begin
            rem_fix_s = fin_pl_s.rem[DEN_W-1:0];
        end
    end

    // Remainder output register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            o_remain <= {DEN_W{1'b0}};
        end else if (!i_stall && stg_valid_s[NSTG]) begin
            o_remain <= rem_fix_s;
        end
    end

    assign unused_s = ^fin_pl_s.den;
`else
    assign o_remain = {DEN_W{1'b0}};
    assign unused_s = ^{fin_pl_s.den, fin_pl_s.rem};
`endif

endmodule

// File: tb/tb_gpu_divider_pipe.sv
// Directed bench for gpu_divider_pipe at default parameters: a vector table with
// hand-computed results, a streaming run with a stall, and a reset mid-flight.
module tb_gpu_divider_pipe;
    import gpu_div_pkg::*;

    localparam int LAT = div_lat(32, 8);

    logic        clock = 1'b0;
    logic        reset;
    logic        i_stall;
    logic        i_valid;
    logic [31:0] i_numer;
    logic [21:0] i_denom;
    logic [7:0]  i_tag;
    logic        o_valid;
    logic [19:0] o_quot;
    logic [21:0] o_remain;
    logic [7:0]  o_tag;
    logic        o_divZero;
    logic        o_ovf;

    int checks = 0;
    int errors = 0;

    gpu_divider_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .i_stall   (i_stall),
        .i_valid   (i_valid),
        .i_numer   (i_numer),
        .i_denom   (i_denom),
        .i_tag     (i_tag),
        .o_valid   (o_valid),
        .o_quot    (o_quot),
        .o_remain  (o_remain),
        .o_tag     (o_tag),
        .o_divZero (o_divZero),
        .o_ovf     (o_ovf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] numer;
        logic [21:0] denom;
        logic [7:0]  tag;
        logic [19:0] quot;
        logic [21:0] rem;
        logic        dz;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic        v;
        logic [19:0] q;
        logic [21:0] r;
        logic [7:0]  tag;
        logic        dz;
        logic        ovf;
    } exp_t;

    vec_t vecs [18];
    exp_t pipe_m [LAT];

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [21:0] exp_rem(input logic [21:0] r);
`ifdef GPU_DIV_REMAINDER_EN
        return r;
`else
        return (r & 22'h000000);
`endif
    endfunction

    // Reference: integer divide on 64-bit values, then saturate.
    function automatic exp_t model(input logic [31:0] n, input logic [21:0] d, input logic [7:0] t);
        exp_t   m;
        longint ln;
        longint ld;
        longint q;
        longint r;
        ln    = longint'($signed(n));
        ld    = longint'($signed(d));
        m.v   = 1'b1;
        m.tag = t;
        if (ld == 64'sd0) begin
            m.dz  = 1'b1;
            m.ovf = 1'b1;
            m.q   = (ln < 64'sd0) ? 20'h80000 : 20'h7FFFF;
            m.r   = n[21:0];
        end else begin
            q    = ln / ld;
            r    = ln % ld;
            m.dz = 1'b0;
            if (q > 64'sd524287) begin
                m.ovf = 1'b1;
                m.q   = 20'h7FFFF;
            end else if (q < -64'sd524288) begin
                m.ovf = 1'b1;
                m.q   = 20'h80000;
            end else begin
                m.ovf = 1'b0;
                m.q   = q[19:0];
            end
            m.r = r[21:0];
        end
        m.r = exp_rem(m.r);
        return m;
    endfunction

    task automatic drive(input logic [31:0] n, input logic [21:0] d, input logic [7:0] t);
        i_valid = 1'b1;
        i_numer = n;
        i_denom = d;
        i_tag   = t;
    endtask

    // One operation alone in the pipe: must appear exactly LAT edges later.
    task automatic run_vec(input vec_t v, input int idx);
        int early;
        early = 0;
        drive(v.numer, v.denom, v.tag);
        tick();
        i_valid = 1'b0;
        i_numer = 32'h0BAD_F00D;
        for (int c = 1; c < LAT; c++) begin
            if (o_valid) early++;
            tick();
        end
        chk($sformatf("v%0d_early", idx), early, 32'd0);
        chk($sformatf("v%0d_valid", idx), o_valid, 1'b1);
        chk($sformatf("v%0d_quot", idx), o_quot, v.quot);
        chk($sformatf("v%0d_rem", idx), o_remain, exp_rem(v.rem));
        chk($sformatf("v%0d_tag", idx), o_tag, v.tag);
        chk($sformatf("v%0d_dz", idx), o_divZero, v.dz);
        chk($sformatf("v%0d_ovf", idx), o_ovf, v.ovf);
        tick();
        chk($sformatf("v%0d_drop", idx), o_valid, 1'b0);
        chk($sformatf("v%0d_hold", idx), o_quot, v.quot);
    endtask

    initial begin
        exp_t        e;
        logic [52:0] snap;
        int          seen;
        int          n_i;
        int          d_i;

        vecs[0]  = '{32'd1000,      22'd7,        8'h5A, 20'd142,     22'd6,       1'b0, 1'b0};
        vecs[1]  = '{-32'sd1000,    22'd7,        8'h01, -20'sd142,   -22'sd6,     1'b0, 1'b0};
        vecs[2]  = '{32'd1000,      -22'sd7,      8'h02, -20'sd142,   22'd6,       1'b0, 1'b0};
        vecs[3]  = '{-32'sd1000,    -22'sd7,      8'h03, 20'd142,     -22'sd6,     1'b0, 1'b0};
        vecs[4]  = '{32'h7FFFFFFF,  22'd1,        8'h04, 20'h7FFFF,   22'd0,       1'b0, 1'b1};
        vecs[5]  = '{32'h80000000,  -22'sd1,      8'h05, 20'h7FFFF,   22'd0,       1'b0, 1'b1};
        vecs[6]  = '{-32'sd5,       22'd0,        8'h06, 20'h80000,   22'h3FFFFB,  1'b1, 1'b1};
        vecs[7]  = '{32'd5,         22'd0,        8'h07, 20'h7FFFF,   22'd5,       1'b1, 1'b1};
        vecs[8]  = '{32'd524287,    22'd1,        8'h08, 20'h7FFFF,   22'd0,       1'b0, 1'b0};
        vecs[9]  = '{32'd524288,    22'd1,        8'h09, 20'h7FFFF,   22'd0,       1'b0, 1'b1};
        vecs[10] = '{-32'sd524288,  22'd1,        8'h0A, 20'h80000,   22'd0,       1'b0, 1'b0};
        vecs[11] = '{-32'sd524289,  22'd1,        8'h0B, 20'h80000,   22'd0,       1'b0, 1'b1};
        vecs[12] = '{32'h80000000,  22'd7,        8'h0C, 20'h80000,   -22'sd2,     1'b0, 1'b1};
        vecs[13] = '{32'd1000,      22'h200000,   8'h0D, 20'd0,       22'd1000,    1'b0, 1'b0};
        vecs[14] = '{32'h80000000,  22'h200000,   8'h0E, 20'd1024,    22'd0,       1'b0, 1'b0};
        vecs[15] = '{32'h7FFFFFFF,  22'd2097151,  8'h0F, 20'd1024,    22'd1023,    1'b0, 1'b0};
        vecs[16] = '{-32'sd7,       22'd1000,     8'h10, 20'd0,       -22'sd7,     1'b0, 1'b0};
        vecs[17] = '{32'd0,         22'd0,        8'h11, 20'h7FFFF,   22'd0,       1'b1, 1'b1};

        reset   = 1'b1;
        i_stall = 1'b0;
        i_valid = 1'b0;
        i_numer = 32'd0;
        i_denom = 22'd0;
        i_tag   = 8'd0;
        tick();
        tick();
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_quot", o_quot, 20'd0);
        chk("rst_rem", o_remain, 22'd0);
        chk("rst_tag", o_tag, 8'd0);
        chk("rst_flags", {o_divZero, o_ovf}, 2'b00);
        reset = 1'b0;

        for (int i = 0; i < 18; i++) run_vec(vecs[i], i);

        // Back-to-back stream with a 3-cycle stall; inputs during stall are ignored.
        for (int i = 0; i < LAT; i++) pipe_m[i].v = 1'b0;
        for (int cyc = 0; cyc < 20 + LAT + 4; cyc++) begin
            n_i = (cyc % 2 == 1) ? -(5000 + 977 * cyc) : (5000 + 977 * cyc);
            d_i = (cyc % 3 == 0) ? -(cyc + 3) : (cyc + 3);
            i_stall = (cyc >= 8 && cyc < 11);
            drive(32'(n_i), 22'(d_i), 8'(8'h80 + cyc));
            i_valid = (cyc < 20);
            e   = model(32'(n_i), 22'(d_i), 8'(8'h80 + cyc));
            e.v = (cyc < 20);
            snap = {o_valid, o_quot, o_remain, o_tag, o_divZero, o_ovf};
            tick();
            if (i_stall) begin
                checks++;
                if (snap !== {o_valid, o_quot, o_remain, o_tag, o_divZero, o_ovf}) begin
                    errors++;
                    $display("FAIL stall_freeze c%0d actual=%0h required=%0h", cyc,
                             {o_valid, o_quot, o_remain, o_tag, o_divZero, o_ovf}, snap);
                end
            end else begin
                for (int i = LAT - 1; i > 0; i--) pipe_m[i] = pipe_m[i-1];
                pipe_m[0] = e;
            end
            chk($sformatf("s%0d_valid", cyc), o_valid, pipe_m[LAT-1].v);
            if (pipe_m[LAT-1].v && !i_stall) begin
                chk($sformatf("s%0d_quot", cyc), o_quot, pipe_m[LAT-1].q);
                chk($sformatf("s%0d_rem", cyc), o_remain, pipe_m[LAT-1].r);
                chk($sformatf("s%0d_tag", cyc), o_tag, pipe_m[LAT-1].tag);
                chk($sformatf("s%0d_flags", cyc), {o_divZero, o_ovf}, {pipe_m[LAT-1].dz, pipe_m[LAT-1].ovf});
            end
        end
        i_stall = 1'b0;
        i_valid = 1'b0;

        // Reset with four operations in flight: nothing may emerge afterwards.
        for (int k = 0; k < 4; k++) begin
            drive(32'd7000 + 32'(k), 22'd3, 8'(8'hC0 + k));
            tick();
        end
        i_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_quot", o_quot, 20'd0);
        chk("mid_rst_tag", o_tag, 8'd0);
        tick();
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < LAT + 3; c++) begin
            tick();
            if (o_valid) seen++;
        end
        chk("post_rst_ghost", seen, 32'd0);
        run_vec(vecs[0], 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
